// File: rtl/ll_multi_fifo.sv
// Multi-queue FIFO: NUM_FIFOS linked-list queues plus one free list sharing a DEPTH-entry RAM.
// Define LL_FORMAL_EN to add immediate invariant assertions and a ghost slot-owner map.
module ll_multi_fifo #(
    parameter int WIDTH     = 4,
    parameter int DEPTH     = 4,
    parameter int NUM_FIFOS = 2,
    parameter int PTR_WIDTH = $clog2(DEPTH),
    parameter int SEL_WIDTH = $clog2(NUM_FIFOS),
    parameter int CNT_WIDTH = $clog2(DEPTH + 1)
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           push,
    input  logic [SEL_WIDTH-1:0]           push_sel,
    input  logic [WIDTH-1:0]               data_in,
    input  logic                           pop,
    input  logic [SEL_WIDTH-1:0]           pop_sel,
    output logic [WIDTH-1:0]               data_out,
    output logic [NUM_FIFOS-1:0]           empty,
    output logic                           full,
    output logic [CNT_WIDTH-1:0]           free_count,
    output logic [NUM_FIFOS*CNT_WIDTH-1:0] count_flat,
    output logic                           push_err,
    output logic                           pop_err
);
    localparam int SEL_SPAN = 1 << SEL_WIDTH;

    logic [WIDTH-1:0]     mem      [DEPTH];
    logic [PTR_WIDTH-1:0] nxt_reg  [DEPTH];
    logic [PTR_WIDTH-1:0] head_reg [NUM_FIFOS];
    logic [PTR_WIDTH-1:0] tail_reg [NUM_FIFOS];
    logic [CNT_WIDTH-1:0] count_reg[NUM_FIFOS];
    logic [PTR_WIDTH-1:0] fhead_reg, ftail_reg;
    logic [CNT_WIDTH-1:0] free_count_reg;
    logic                 push_err_reg, pop_err_reg;

    // Views padded to the full select range so out-of-range selects read as invalid/empty.
    logic [SEL_SPAN-1:0]  sel_valid, empty_ext;
    logic [PTR_WIDTH-1:0] head_ext [SEL_SPAN];
    logic [PTR_WIDTH-1:0] tail_ext [SEL_SPAN];
    logic [CNT_WIDTH-1:0] count_ext[SEL_SPAN];

    generate
        for (genvar gi = 0; gi < SEL_SPAN; gi++) begin : g_sel
            if (gi < NUM_FIFOS) begin : g_q
                assign sel_valid[gi] = 1'b1;
                assign empty_ext[gi] = (count_reg[gi] == '0);
                assign head_ext[gi]  = head_reg[gi];
                assign tail_ext[gi]  = tail_reg[gi];
                assign count_ext[gi] = count_reg[gi];
                assign empty[gi]     = empty_ext[gi];
                assign count_flat[gi*CNT_WIDTH +: CNT_WIDTH] = count_reg[gi];
            end else begin : g_pad
                assign sel_valid[gi] = 1'b0;
                assign empty_ext[gi] = 1'b1;
                assign head_ext[gi]  = '0;
                assign tail_ext[gi]  = '0;
                assign count_ext[gi] = '0;
            end
        end
    endgenerate

    logic                 push_ok, pop_ok, push_into_empty, pop_single, free_one;
    logic                 free_link;
    logic [PTR_WIDTH-1:0] alloc_slot, pop_slot, push_tail;

    assign full            = (free_count_reg == '0);
    assign push_ok         = push & ~full & sel_valid[push_sel];
    assign pop_ok          = pop & sel_valid[pop_sel] & ~empty_ext[pop_sel];
    assign alloc_slot      = fhead_reg;
    assign pop_slot        = head_ext[pop_sel];
    assign push_tail       = tail_ext[push_sel];
    assign push_into_empty = empty_ext[push_sel];
    assign pop_single      = (count_ext[pop_sel] == CNT_WIDTH'(1));
    assign free_one        = (free_count_reg == CNT_WIDTH'(1));
    // Only link behind ftail when ftail still names a live free-list entry after this edge.
    assign free_link       = pop_ok & ~full & ~(push_ok & free_one);

    assign data_out   = mem[pop_slot];
    assign free_count = free_count_reg;
    assign push_err   = push_err_reg;
    assign pop_err    = pop_err_reg;

    always_ff @(posedge clk) begin
        if (!rst && push_ok) begin
            mem[alloc_slot] <= data_in;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                nxt_reg[i] <= PTR_WIDTH'(i + 1);
            end
            for (int q = 0; q < NUM_FIFOS; q++) begin
                head_reg[q]  <= '0;
                tail_reg[q]  <= '0;
                count_reg[q] <= '0;
            end
            fhead_reg      <= '0;
            ftail_reg      <= PTR_WIDTH'(DEPTH - 1);
            free_count_reg <= CNT_WIDTH'(DEPTH);
            push_err_reg   <= 1'b0;
            pop_err_reg    <= 1'b0;
        end else begin
            push_err_reg <= push & ~push_ok;
            pop_err_reg  <= pop & ~pop_ok;

            if (push_ok && !push_into_empty) begin
                nxt_reg[push_tail] <= alloc_slot;
            end
            if (free_link) begin
                nxt_reg[ftail_reg] <= pop_slot;
            end

            // A freed slot becomes fhead whenever the free list would otherwise be stale.
            if (push_ok && pop_ok && free_one) begin
                fhead_reg <= pop_slot;
            end else if (push_ok) begin
                fhead_reg <= nxt_reg[alloc_slot];
            end else if (pop_ok && full) begin
                fhead_reg <= pop_slot;
            end
            if (pop_ok) begin
                ftail_reg <= pop_slot;
            end
            free_count_reg <= free_count_reg + CNT_WIDTH'(pop_ok) - CNT_WIDTH'(push_ok);

            for (int q = 0; q < NUM_FIFOS; q++) begin
                if (push_ok && push_sel == SEL_WIDTH'(q)) begin
                    tail_reg[q] <= alloc_slot;
                    if (push_into_empty) begin
                        head_reg[q] <= alloc_slot;
                    end
                end
                if (pop_ok && pop_sel == SEL_WIDTH'(q)) begin
                    // nxt of a single-entry head is not yet linked to the slot pushed this cycle.
                    if (push_ok && push_sel == pop_sel && pop_single) begin
                        head_reg[q] <= alloc_slot;
                    end else begin
                        head_reg[q] <= nxt_reg[pop_slot];
                    end
                end
                count_reg[q] <= count_reg[q]
                              + CNT_WIDTH'(push_ok && push_sel == SEL_WIDTH'(q))
                              - CNT_WIDTH'(pop_ok && pop_sel == SEL_WIDTH'(q));
            end
        end
    end

`ifdef LL_FORMAL_EN
    logic [SEL_WIDTH:0] owner_reg [DEPTH];
    logic               check_en_reg;
    logic               env_push_bad_reg, env_pop_bad_reg;
    int                 owned [NUM_FIFOS];
    int                 total_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                owner_reg[i] <= (SEL_WIDTH+1)'(NUM_FIFOS);
            end
            check_en_reg     <= 1'b1;
            env_push_bad_reg <= 1'b0;
            env_pop_bad_reg  <= 1'b0;
        end else begin
            if (push_ok) owner_reg[alloc_slot] <= {1'b0, push_sel};
            if (pop_ok)  owner_reg[pop_slot]   <= (SEL_WIDTH+1)'(NUM_FIFOS);
            env_push_bad_reg <= push & (full | ~sel_valid[push_sel]);
            env_pop_bad_reg  <= pop & (~sel_valid[pop_sel] | empty_ext[pop_sel]);
        end
    end

    always_comb begin
        total_count = 0;
        for (int q = 0; q < NUM_FIFOS; q++) begin
            owned[q] = 0;
            total_count = total_count + int'(count_reg[q]);
            for (int i = 0; i < DEPTH; i++) begin
                if (owner_reg[i] == (SEL_WIDTH+1)'(q)) owned[q] = owned[q] + 1;
            end
        end
    end

    always @(posedge clk) begin
        if (check_en_reg === 1'b1 && !rst) begin
            assert (int'(free_count_reg) + total_count == DEPTH);
            assert (push_err_reg == env_push_bad_reg);
            assert (pop_err_reg == env_pop_bad_reg);
            for (int q = 0; q < NUM_FIFOS; q++) begin
                assert (empty[q] == (count_reg[q] == '0));
                assert (count_reg[q] == '0
                        || ((head_reg[q] == tail_reg[q]) == (count_reg[q] == CNT_WIDTH'(1))));
                assert (owned[q] == int'(count_reg[q]));
            end
        end
    end
`endif

endmodule

// File: doc/ll_multi_fifo.md
Name: ll_multi_fifo

Overview:
- Shared-storage multi-queue FIFO: NUM_FIFOS logical queues share one DEPTH-entry data RAM, threaded as per-queue singly linked lists plus one free list.
- Next generation of the linked-list FIFO:
  - parametrised channel count;
  - per-queue and free-list occupancy outputs;
  - illegal-operation detection in RTL instead of environment constraints;
  - optional built-in formal invariants.
- Drop-in storage element under the refinement-proof harness and scoreboard flow.

Parameters:
- WIDTH, 4, data word width.
- DEPTH, 4, total shared entries; power of two, >=2.
- NUM_FIFOS, 2, number of logical queues; >=2.
- PTR_WIDTH, $clog2(DEPTH), slot pointer width.
- SEL_WIDTH, $clog2(NUM_FIFOS), queue select width.
- CNT_WIDTH, $clog2(DEPTH+1), occupancy counter width.

Ports:
- clk  input  1  clock; all state updates on posedge.
- rst  input  1  synchronous, active-high reset.
- push  input  1  enqueue request.
- push_sel  input  SEL_WIDTH  target queue for push.
- data_in  input  WIDTH  push data.
- pop  input  1  dequeue request.
- pop_sel  input  SEL_WIDTH  source queue for pop; also selects data_out.
- data_out  output  WIDTH  head word of queue pop_sel, combinational (first-word fall-through).
- empty  output  NUM_FIFOS  bit q high iff count of queue q == 0.
- full  output  1  high iff free_count == 0.
- free_count  output  CNT_WIDTH  entries on free list.
- count_flat  output  NUM_FIFOS*CNT_WIDTH  per-queue occupancy; queue q at bits [q*CNT_WIDTH +: CNT_WIDTH].
- push_err  output  1  registered; high one cycle after a rejected push.
- pop_err  output  1  registered; high one cycle after a rejected pop.

Behaviour:
- State:
  - mem[DEPTH] data; nxt[DEPTH] pointers.
  - Per queue: head, tail, count.
  - Free list: fhead, ftail, free_count.
- Reset, 1 cycle:
  - free list = slot 0->1->...->DEPTH-1; fhead=0, ftail=DEPTH-1, free_count=DEPTH.
  - All queue counts 0; heads/tails 0.
  - empty all ones, full=0, push_err=pop_err=0.
  - data_out is don't-care while empty[pop_sel].
  - rst asserted mid-operation discards all contents on the next edge. Push/pop in the rst cycle are ignored and flag nothing.
- Legal push: push & ~full & push_sel<NUM_FIFOS.
  - Slot s=fhead; mem[s]<=data_in.
  - If queue empty, head<=s; else nxt[tail]<=s.
  - tail<=s; count+1; fhead<=nxt[s]; free_count-1.
- Legal pop: pop & ~empty[pop_sel] & pop_sel<NUM_FIFOS.
  - Slot h=head; head<=nxt[h]; count-1.
  - h appended at free tail: nxt[ftail]<=h, ftail<=h, free_count+1.
- Rejected operations:
  - Illegal push: no state change; push_err<=1.
  - Illegal pop: no state change; pop_err<=1.
  - Error flags clear the next cycle unless re-triggered.
  - Push and pop legality are evaluated independently on pre-edge state.
- full is sampled pre-edge: push while full is rejected even with a simultaneous legal pop. No same-cycle slot reuse.
- Simultaneous legal push and pop:
  - Different queues: both updates apply. Free_count unchanged.
  - Same queue, count==1: popped slot freed; pushed slot becomes both head and tail; count stays 1.
  - Same queue, count>1: head advances, tail links new slot; count unchanged.
  - free_count==1 with push and pop: allocated slot leaves, freed slot h becomes fhead=ftail=h; free_count stays 1.
- All counters are CNT_WIDTH, non-wrapping by construction. Pointers wrap naturally within PTR_WIDTH.
- No output depends on data_in combinationally. data_out depends on pop_sel and state only.

Optional Feature:
- Macro LL_FORMAL_EN.
- Defined: immediate assertions on registered state each cycle after reset:
  - free_count + sum(counts) == DEPTH.
  - empty[q] == (count_q==0).
  - A non-empty queue's head equals its tail iff count==1.
  - No error flag follows a cycle that violated only environment-legal inputs.
  - Also adds an output-free ghost owner map owner[DEPTH] (queue id, or NUM_FIFOS for free), updated on push/pop. Asserts popcount(owner==q) == count_q.
- Undefined: no assertions, no ghost state; identical port behaviour.

Test Plan:
- Reset, then read outputs -> free_count=4, full=0, empty=2'b11, count_flat=0, push_err=pop_err=0.
- Push 0xA,0xB to q0, 0xC to q1; pop q0 twice -> data_out 0xA then 0xB; q0 empty; free_count=3, then back to 4 after popping q1 (0xC).
- Fill DEPTH=4 with q1, then push q0 with simultaneous pop q1 -> push rejected, push_err=1 next cycle; free_count=1; q0 stays empty.
- q0 holds one word 0x5; same-cycle push 0x6 and pop q0 -> data_out was 0x5; next cycle count_q0=1, data_out(pop_sel=0)=0x6.
- Pop empty q1 with legal push q0 -> pop_err=1, count_q0=1, free_count=3.
- Assert rst mid-stream with 3 entries queued -> next cycle free_count=4, empty=2'b11; with LL_FORMAL_EN no assertion fires over a 200-cycle random legal run.
